// File: rtl/out_mon_pkg.sv
// Shared types and helpers for out_event_monitor.
package out_mon_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Increment by inc, saturating at the largest value that fits in cnt_w bits (cnt_w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic inc,
                                          input int unsigned cnt_w);
    logic [31:0] max_v;
    max_v = (cnt_w >= 32) ? '1 : ((32'd1 << cnt_w) - 32'd1);
    if (inc && (cnt < max_v)) begin
      return cnt + 32'd1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/out_event_monitor_edge.sv
// Rising-edge detector on the monitored bit.
// OUT_MON_SYNC_EN: adds a second sample flop for an asynchronous source.
module edge_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic rise
);

  logic samp_q;
  logic prev_q;

`ifdef OUT_MON_SYNC_EN
  logic meta_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      samp_q <= 1'b0;
    end else begin
      meta_q <= in_bit;
      samp_q <= meta_q;
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_q <= 1'b0;
    end else begin
      samp_q <= in_bit;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= samp_q;
    end
  end

  assign rise = samp_q & ~prev_q;

endmodule

// File: rtl/out_event_monitor.sv
// Counts rising edges of in_bit per programmable window and reports each count on valid/ready.
// OUT_MON_SYNC_EN selects a 2-flop input synchronizer in edge_rise_det.
module out_event_monitor
  import out_mon_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  input  logic             in_bit,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_sat,
  output logic             ovf,
  input  logic             clr_ovf
);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] ev_cnt_q, ev_cnt_d;
  logic             sat_q, sat_d;
  logic             rpt_valid_q, rpt_valid_d;
  logic [CNT_W-1:0] rpt_count_q, rpt_count_d;
  logic             rpt_sat_q, rpt_sat_d;
  logic             ovf_q, ovf_d;

  logic             rise;
  logic [CNT_W-1:0] ev_inc;
  logic             sat_now;
  logic             close;
  logic             drop;

  edge_rise_det u_edge (
    .clk    (clk),
    .reset  (reset),
    .in_bit (in_bit),
    .rise   (rise)
  );

  assign ev_inc  = CNT_W'(sat_inc(32'(ev_cnt_q), rise, CNT_W));
  assign sat_now = rise && (ev_cnt_q == {CNT_W{1'b1}});

  always_comb begin
    state_d   = state_q;
    win_len_d = win_len_q;
    win_cnt_d = win_cnt_q;
    ev_cnt_d  = ev_cnt_q;
    sat_d     = sat_q;
    close     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        win_cnt_d = '0;
        ev_cnt_d  = '0;
        sat_d     = 1'b0;
        if (en) begin
          state_d   = ST_RUN;
          win_len_d = (win_len == '0) ? WIN_W'(1) : win_len;
        end
      end
      ST_RUN: begin
        if (!en) begin
          // Partial window is abandoned; any held report stays untouched.
          state_d   = ST_IDLE;
          win_cnt_d = '0;
          ev_cnt_d  = '0;
          sat_d     = 1'b0;
        end else if (win_cnt_q == win_len_q - WIN_W'(1)) begin
          close     = 1'b1;
          win_cnt_d = '0;
          ev_cnt_d  = '0;
          sat_d     = 1'b0;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          ev_cnt_d  = ev_inc;
          sat_d     = sat_q | sat_now;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rpt_valid_d = rpt_valid_q;
    rpt_count_d = rpt_count_q;
    rpt_sat_d   = rpt_sat_q;
    drop        = 1'b0;
    if (close) begin
      if (rpt_valid_q && !rpt_ready) begin
        drop = 1'b1;
      end else begin
        rpt_valid_d = 1'b1;
        rpt_count_d = ev_inc;
        rpt_sat_d   = sat_q | sat_now;
      end
    end else if (rpt_valid_q && rpt_ready) begin
      rpt_valid_d = 1'b0;
    end
    ovf_d = drop | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      win_len_q   <= '0;
      win_cnt_q   <= '0;
      ev_cnt_q    <= '0;
      sat_q       <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_count_q <= '0;
      rpt_sat_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_len_q   <= win_len_d;
      win_cnt_q   <= win_cnt_d;
      ev_cnt_q    <= ev_cnt_d;
      sat_q       <= sat_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_count_q <= rpt_count_d;
      rpt_sat_q   <= rpt_sat_d;
      ovf_q       <= ovf_d;
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign rpt_count = rpt_count_q;
  assign rpt_sat   = rpt_sat_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_out_event_monitor.sv
// Directed bench for out_event_monitor: default instance plus a CNT_W=4 instance on shared inputs.
module tb_out_event_monitor;

`ifdef OUT_MON_SYNC_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 2;
`endif

  logic        clk;
  logic        reset;
  logic        en;
  logic [15:0] win_len;
  logic        in_bit;
  logic        rpt_ready;
  logic        clr_ovf;

  logic        rpt_valid, rpt_sat, ovf;
  logic [7:0]  rpt_count;
  logic        rpt_valid4, rpt_sat4, ovf4;
  logic [3:0]  rpt_count4;

  int vectors = 0;
  int miscompares = 0;

  out_event_monitor u_dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .win_len   (win_len),
    .in_bit    (in_bit),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_count (rpt_count),
    .rpt_sat   (rpt_sat),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  out_event_monitor #(.CNT_W(4), .WIN_W(16)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .win_len   (win_len),
    .in_bit    (in_bit),
    .rpt_valid (rpt_valid4),
    .rpt_ready (rpt_ready),
    .rpt_count (rpt_count4),
    .rpt_sat   (rpt_sat4),
    .ovf       (ovf4),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n one-cycle pulses spaced by one low cycle, then idle until total cycles have elapsed.
  task automatic pulses(input int n, input int total);
    for (int i = 0; i < n; i++) begin
      in_bit = 1'b1;
      cyc();
      in_bit = 1'b0;
      cyc();
    end
    repeat (total - 2 * n) cyc();
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; win_len = '0; in_bit = 1'b0; rpt_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    chk("rst_valid", 32'(rpt_valid), 0);
    chk("rst_count", 32'(rpt_count), 0);
    chk("rst_sat", 32'(rpt_sat), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_valid4", 32'(rpt_valid4), 0);
    reset = 1'b1;
    cyc();

    // 1: three pulses in a 10-cycle window
    win_len = 16'd10; en = 1'b1; rpt_ready = 1'b1;
    cyc();
    pulses(3, 6);
    repeat (3) cyc();
    chk("t1_pre_valid", 32'(rpt_valid), 0);
    cyc();
    chk("t1_valid", 32'(rpt_valid), 1);
    chk("t1_count", 32'(rpt_count), 3);
    chk("t1_sat", 32'(rpt_sat), 0);
    en = 1'b0;
    cyc();
    chk("t1_valid_drop", 32'(rpt_valid), 0);

    // 2: 25 rises in 100 cycles; CNT_W=4 saturates
    win_len = 16'd100; en = 1'b1;
    cyc();
    for (int i = 0; i < 25; i++) begin
      in_bit = 1'b1;
      cyc();
      cyc();
      in_bit = 1'b0;
      cyc();
      cyc();
    end
    chk("t2_valid", 32'(rpt_valid), 1);
    chk("t2_count8", 32'(rpt_count), 25);
    chk("t2_sat8", 32'(rpt_sat), 0);
    chk("t2_count4", 32'(rpt_count4), 15);
    chk("t2_sat4", 32'(rpt_sat4), 1);
    in_bit = 1'b1;
    cyc();
    chk("t2_valid_clr", 32'(rpt_valid), 0);
    in_bit = 1'b0;
    repeat (98) cyc();
    cyc();
    chk("t2_w2_valid", 32'(rpt_valid4), 1);
    chk("t2_w2_count4", 32'(rpt_count4), 1);
    chk("t2_w2_sat4", 32'(rpt_sat4), 0);
    en = 1'b0;
    cyc();

    // 3: held report, second window dropped, then drain and clear ovf
    win_len = 16'd16; rpt_ready = 1'b0; en = 1'b1;
    cyc();
    pulses(2, 16);
    chk("t3_a_valid", 32'(rpt_valid), 1);
    chk("t3_a_count", 32'(rpt_count), 2);
    chk("t3_a_ovf", 32'(ovf), 0);
    pulses(5, 16);
    chk("t3_b_valid", 32'(rpt_valid), 1);
    chk("t3_b_count", 32'(rpt_count), 2);
    chk("t3_b_ovf", 32'(ovf), 1);
    en = 1'b0; rpt_ready = 1'b1;
    cyc();
    chk("t3_drain_valid", 32'(rpt_valid), 0);
    chk("t3_drain_ovf", 32'(ovf), 1);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("t3_clr_ovf", 32'(ovf), 0);

    // 4: ready asserted exactly in the close cycle
    rpt_ready = 1'b0; en = 1'b1;
    cyc();
    pulses(1, 16);
    chk("t4_held_count", 32'(rpt_count), 1);
    pulses(3, 15);
    rpt_ready = 1'b1;
    cyc();
    chk("t4_valid", 32'(rpt_valid), 1);
    chk("t4_count", 32'(rpt_count), 3);
    chk("t4_ovf", 32'(ovf), 0);
    en = 1'b0;
    cyc();
    chk("t4_valid_drop", 32'(rpt_valid), 0);

    // 5: en low mid-window, then asynchronous reset mid-window
    en = 1'b1;
    cyc();
    pulses(2, 6);
    en = 1'b0;
    cyc();
    chk("t5_no_rpt", 32'(rpt_valid), 0);
    repeat (20) cyc();
    chk("t5_no_rpt_late", 32'(rpt_valid), 0);
    rpt_ready = 1'b0; en = 1'b1;
    cyc();
    pulses(1, 16);
    chk("t5_fresh_count", 32'(rpt_count), 1);
    pulses(0, 16);
    chk("t5_ovf", 32'(ovf), 1);
    repeat (5) cyc();
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rpt_valid), 0);
    chk("t5_rst_count", 32'(rpt_count), 0);
    chk("t5_rst_ovf", 32'(ovf), 0);
    en = 1'b0; rpt_ready = 1'b1;
    cyc();
    reset = 1'b1;
    cyc();

    // 6: win_len=0 closes every cycle; steady-high input counts once with known latency
    win_len = '0; en = 1'b1;
    cyc();
    cyc();
    chk("t6_first_valid", 32'(rpt_valid), 1);
    chk("t6_first_count", 32'(rpt_count), 0);
    in_bit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("t6_count_%0d", i), 32'(rpt_count), (i + 1 == Lat) ? 1 : 0);
      chk($sformatf("t6_valid_%0d", i), 32'(rpt_valid), 1);
    end
    en = 1'b0; in_bit = 1'b0;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
